// File: rtl/pia_input_debounce_if.sv
// pia_input_debounce_if: switch-conditioning bus between the cabinet inputs and the PIA port A.
// The slave side is the debouncer. The master side drives raw_in/e_sync and observes the outputs.
interface pia_input_debounce_if #(
  parameter int unsigned WIDTH = 8
);

  logic             e_sync;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] pa_in;
  logic             ca1;
  logic [WIDTH-1:0] changed;

  modport master (
    output e_sync,
    output raw_in,
    input  pa_in,
    input  ca1,
    input  changed
  );

  modport slave (
    input  e_sync,
    input  raw_in,
    output pa_in,
    output ca1,
    output changed
  );

endinterface

// File: rtl/pia_input_debounce.sv
// pia_input_debounce: synchronizes and debounces cabinet switches for the mc6821 port A.
// It also raises a CA1 change strobe whenever any debounced bit updates.
// Optional build macro INPUT_INVERT_EN inverts raw_in ahead of the synchronizer,
// so that active-low switches read as active-high on pa_in.
module pia_input_debounce #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DEBOUNCE_TICKS = 16,
  parameter int unsigned STROBE_TICKS   = 4
) (
  input logic                 clock,
  input logic                 reset,
  pia_input_debounce_if.slave bus
);

  localparam int unsigned CNT_W = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int unsigned STB_W = (STROBE_TICKS > 2) ? $clog2(STROBE_TICKS) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [STB_W-1:0] STB_LOAD = STB_W'(STROBE_TICKS - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [WIDTH-1:0]            raw_cond;
  logic [WIDTH-1:0]            sync1_q;
  logic [WIDTH-1:0]            sync2_q;

  logic [WIDTH-1:0]            pa_q;
  logic [WIDTH-1:0]            pa_d;
  logic [WIDTH-1:0]            chg_q;
  logic [WIDTH-1:0]            chg_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;

  state_t                      state_q;
  state_t                      state_d;
  logic [STB_W-1:0]            stb_q;
  logic [STB_W-1:0]            stb_d;
  logic                        ca1_q;
  logic                        ca1_d;

  // Input polarity selection ahead of the first synchronizer stage.
`ifdef INPUT_INVERT_EN
  assign raw_cond = ~bus.raw_in;
`else
  assign raw_cond = bus.raw_in;
`endif

  // Two-flop synchronizer. It runs every clock and is not gated by e_sync.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_cond;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce. A differing level must persist for DEBOUNCE_TICKS samples.
  // Any matching sample restarts the count.
  always_comb begin
    pa_d  = pa_q;
    chg_d = '0;
    cnt_d = cnt_q;
    if (bus.e_sync) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync2_q[i] == pa_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == DEB_LAST) begin
          pa_d[i]  = sync2_q[i];
          cnt_d[i] = '0;
          chg_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced level, per-bit counters and the one-clock change pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pa_q  <= '0;
      chg_q <= '0;
      cnt_q <= '0;
    end else begin
      pa_q  <= pa_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end

  // Strobe FSM next state. A change always wins over terminal count, so a
  // retrigger reloads the hold time and never opens a low gap on ca1.
  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    case (state_q)
      ST_IDLE: begin
        if (|chg_q) begin
          state_d = ST_ACTIVE;
          stb_d   = STB_LOAD;
        end
      end
      ST_ACTIVE: begin
        if (|chg_q) begin
          stb_d = STB_LOAD;
        end else if (bus.e_sync) begin
          if (stb_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            stb_d = stb_q - STB_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        stb_d   = '0;
      end
    endcase
    ca1_d = (state_d == ST_ACTIVE);
  end

  // Strobe FSM state register, with ca1 registered alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      stb_q   <= '0;
      ca1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      ca1_q   <= ca1_d;
    end
  end

  assign bus.pa_in   = pa_q;
  assign bus.changed = chg_q;
  assign bus.ca1     = ca1_q;

endmodule

// File: tb/tb_pia_input_debounce.sv
// tb_pia_input_debounce: directed test of the switch debouncer and its CA1 change strobe.
// The e_sync sample tick is issued every 4 clocks.
module tb_pia_input_debounce;

  localparam int unsigned WIDTH = 8;

  logic clock = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  int rise_cnt = 0;
  int chg_cnt  = 0;
  logic ca1_prev = 1'b0;

  int base_r;
  int base_c;
  logic [7:0] val;

  always #5 clock = ~clock;

  pia_input_debounce_if #(.WIDTH(WIDTH)) bus ();

  pia_input_debounce #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_TICKS (16),
    .STROBE_TICKS   (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Count ca1 rising edges and clocks with any changed bit, sampled mid-cycle.
  always @(negedge clock) begin
    if (bus.ca1 === 1'b1 && ca1_prev !== 1'b1) rise_cnt++;
    if (bus.changed !== 8'h00) chg_cnt++;
    ca1_prev = bus.ca1;
  end

  // Physical switch levels for a wanted logical level.
  function automatic logic [7:0] phys(input logic [7:0] v);
`ifdef INPUT_INVERT_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic tick();
    bus.e_sync = 1'b1;
    @(negedge clock);
    bus.e_sync = 1'b0;
  endtask

  task automatic gap_tick();
    clk(3);
    tick();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clk(2);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    bus.e_sync = 1'b0;
    bus.raw_in = phys(8'h00);
    clk(2);
    check("reset_pa", 32'(bus.pa_in), 32'h00);
    check("reset_ca1", 32'(bus.ca1), 32'h0);
    check("reset_changed", 32'(bus.changed), 32'h00);
    reset = 1'b0;

    // Idle inputs: nothing moves.
    base_r = rise_cnt; base_c = chg_cnt;
    repeat (50) gap_tick();
    check("t1_pa", 32'(bus.pa_in), 32'h00);
    check("t1_ca1", 32'(bus.ca1), 32'h0);
    check("t1_rises", 32'(rise_cnt - base_r), 32'd0);
    check("t1_changes", 32'(chg_cnt - base_c), 32'd0);

    // Clean step on bit 0.
    base_r = rise_cnt;
    bus.raw_in = phys(8'h01);
    repeat (15) gap_tick();
    check("t2_pa_tick15", 32'(bus.pa_in), 32'h00);
    gap_tick();
    check("t2_pa_tick16", 32'(bus.pa_in), 32'h01);
    check("t2_changed", 32'(bus.changed), 32'h01);
    clk(1);
    check("t2_changed_gone", 32'(bus.changed), 32'h00);
    check("t2_ca1_up", 32'(bus.ca1), 32'h1);
    clk(2);
    repeat (3) gap_tick();
    check("t2_ca1_hold3", 32'(bus.ca1), 32'h1);
    gap_tick();
    check("t2_ca1_drop4", 32'(bus.ca1), 32'h0);
    check("t2_rises", 32'(rise_cnt - base_r), 32'd1);

    // Bit 3 bounces for 50 ticks, then settles high.
    base_r = rise_cnt; base_c = chg_cnt;
    val = 8'h01;
    for (int i = 0; i < 50; i++) begin
      if ((i % 3) == 0 && i < 48) begin
        val[3] = ~val[3];
        bus.raw_in = phys(val);
      end
      gap_tick();
    end
    check("t3_pa_bounce", 32'(bus.pa_in), 32'h01);
    check("t3_no_change", 32'(chg_cnt - base_c), 32'd0);
    val = 8'h09;
    bus.raw_in = phys(val);
    repeat (15) gap_tick();
    check("t3_pa_tick15", 32'(bus.pa_in), 32'h01);
    gap_tick();
    check("t3_pa_tick16", 32'(bus.pa_in), 32'h09);
    check("t3_changed", 32'(bus.changed), 32'h08);
    repeat (5) gap_tick();
    check("t3_ca1_end", 32'(bus.ca1), 32'h0);
    check("t3_rises", 32'(rise_cnt - base_r), 32'd1);

    // Two bits stepping together give one update and one strobe.
    bus.raw_in = phys(8'h00);
    do_reset();
    check("t4_pa_reset", 32'(bus.pa_in), 32'h00);
    base_r = rise_cnt; base_c = chg_cnt;
    bus.raw_in = phys(8'h81);
    repeat (15) gap_tick();
    check("t4_pa_tick15", 32'(bus.pa_in), 32'h00);
    gap_tick();
    check("t4_pa_tick16", 32'(bus.pa_in), 32'h81);
    check("t4_changed", 32'(bus.changed), 32'h81);
    repeat (5) gap_tick();
    check("t4_rises", 32'(rise_cnt - base_r), 32'd1);
    check("t4_change_clocks", 32'(chg_cnt - base_c), 32'd1);

    // Retrigger: bit 2 is accepted 2 ticks after bit 1, inside the strobe.
    base_r = rise_cnt;
    bus.raw_in = phys(8'h83);
    gap_tick();
    gap_tick();
    bus.raw_in = phys(8'h87);
    repeat (13) gap_tick();
    check("t5_pa_tick15", 32'(bus.pa_in), 32'h81);
    gap_tick();
    check("t5_changed_b1", 32'(bus.changed), 32'h02);
    check("t5_pa_tick16", 32'(bus.pa_in), 32'h83);
    gap_tick();
    check("t5_ca1_tick17", 32'(bus.ca1), 32'h1);
    gap_tick();
    check("t5_changed_b2", 32'(bus.changed), 32'h04);
    check("t5_pa_tick18", 32'(bus.pa_in), 32'h87);
    repeat (3) gap_tick();
    check("t5_ca1_tick21", 32'(bus.ca1), 32'h1);
    gap_tick();
    check("t5_ca1_tick22", 32'(bus.ca1), 32'h0);
    check("t5_rises", 32'(rise_cnt - base_r), 32'd1);

    // Reset 8 ticks into a debounce toward 8'h10.
    bus.raw_in = phys(8'h10);
    repeat (8) gap_tick();
    check("t6_pa_mid", 32'(bus.pa_in), 32'h87);
    reset = 1'b1;
    #1;
    check("t6_pa_in_reset", 32'(bus.pa_in), 32'h00);
    check("t6_ca1_in_reset", 32'(bus.ca1), 32'h0);
    clk(2);
    reset = 1'b0;
    base_r = rise_cnt;
    repeat (15) gap_tick();
    check("t6_pa_tick15", 32'(bus.pa_in), 32'h00);
    gap_tick();
    check("t6_pa_tick16", 32'(bus.pa_in), 32'h10);
    check("t6_changed", 32'(bus.changed), 32'h10);
    repeat (5) gap_tick();
    check("t6_rises", 32'(rise_cnt - base_r), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
